// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V control path: FSM states, opcodes,
// datapath select codes and the per-state Moore control word.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALRLINK = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] A_PC    = 2'b00;
    localparam logic [1:0] A_OLDPC = 2'b01;
    localparam logic [1:0] A_RS1   = 2'b10;
    localparam logic [1:0] A_ZERO  = 2'b11;

    localparam logic [1:0] B_RS2  = 2'b00;
    localparam logic [1:0] B_IMM  = 2'b01;
    localparam logic [1:0] B_FOUR = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // fetch marks FETCH, whose ir_write/pc_update are qualified by mem_ready.
    typedef struct packed {
        logic       fetch;
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic       mem_write;
        logic       adr_src;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic ctrl_t ctrl_of(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.fetch      = 1'b1;
                c.alu_src_a  = A_PC;
                c.alu_src_b  = B_FOUR;
                c.alu_op     = ALU_ADD;
                c.result_src = RES_ALURES;
            end
            S_DECODE: begin
                c.alu_src_a = A_OLDPC;
                c.alu_src_b = B_IMM;
                c.alu_op    = ALU_ADD;
            end
            S_MEMADR: begin
                c.alu_src_a = A_RS1;
                c.alu_src_b = B_IMM;
                c.alu_op    = ALU_ADD;
            end
            S_MEMREAD: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                c.result_src = RES_RDATA;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
                c.mem_write  = 1'b1;
            end
            S_EXECUTER: begin
                c.alu_src_a = A_RS1;
                c.alu_src_b = B_RS2;
                c.alu_op    = ALU_FUNCT;
            end
            S_EXECUTEI: begin
                c.alu_src_a = A_RS1;
                c.alu_src_b = B_IMM;
                c.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a  = A_RS1;
                c.alu_src_b  = B_RS2;
                c.alu_op     = ALU_SUB;
                c.result_src = RES_ALUOUT;
                c.branch     = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a  = A_OLDPC;
                c.alu_src_b  = B_FOUR;
                c.alu_op     = ALU_ADD;
                c.result_src = RES_ALUOUT;
                c.pc_update  = 1'b1;
            end
            S_JALR: begin
                c.alu_src_a  = A_RS1;
                c.alu_src_b  = B_IMM;
                c.alu_op     = ALU_ADD;
                c.result_src = RES_ALURES;
                c.pc_update  = 1'b1;
            end
            S_JALRLINK: begin
                c.alu_src_a = A_OLDPC;
                c.alu_src_b = B_FOUR;
                c.alu_op    = ALU_ADD;
            end
            S_LUI: begin
                c.alu_src_a = A_ZERO;
                c.alu_src_b = B_IMM;
                c.alu_op    = ALU_ADD;
            end
            S_AUIPC: begin
                c.alu_src_a = A_OLDPC;
                c.alu_src_b = B_IMM;
                c.alu_op    = ALU_ADD;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/main_fsm.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback and
// drives every datapath enable and select from a registered control word.
module main_fsm
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       pc_update,
    output logic       branch,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       adr_src,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal_instr
);

    state_t state_q, state_d;
    ctrl_t  ctrl_q;
    logic   op_illegal;

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch behind.
        state_d    = S_FETCH;
        op_illegal = 1'b0;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECUTER;
                    OP_I:              state_d = S_EXECUTEI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default: begin
                        state_d    = S_FETCH;
                        op_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER, S_EXECUTEI, S_JAL, S_JALRLINK, S_LUI, S_AUIPC:
                        state_d = S_ALUWB;
            S_JALR:     state_d = S_JALRLINK;
            default:    state_d = S_FETCH;
        endcase
    end

    // The control word is registered alongside the state from the same next-state
    // value, so it always equals the decode of state_q without a comb decoder.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so state and control word update together.
        if (reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= ctrl_of(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_of(state_d);
        end
    end

    assign pc_update     = !reset && (ctrl_q.pc_update || (ctrl_q.fetch && mem_ready));
    assign ir_write      = !reset && ctrl_q.fetch && mem_ready;
    assign branch        = !reset && ctrl_q.branch;
    assign reg_write     = !reset && ctrl_q.reg_write;
    assign mem_write     = !reset && ctrl_q.mem_write;
    assign illegal_instr = !reset && (state_q == S_DECODE) && op_illegal;
    assign adr_src       = ctrl_q.adr_src;
    assign result_src    = ctrl_q.result_src;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign alu_op        = ctrl_q.alu_op;

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: per-cycle comparison of all outputs against
// hand-written per-state control vectors.
module tb_main_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic       mem_ready;
    logic       pc_update, branch, ir_write, reg_write, mem_write, adr_src;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic       illegal_instr;

    int total = 0;
    int bad   = 0;

    main_fsm dut (
        .clk          (clk),
        .reset        (reset),
        .op           (op),
        .mem_ready    (mem_ready),
        .pc_update    (pc_update),
        .branch       (branch),
        .ir_write     (ir_write),
        .reg_write    (reg_write),
        .mem_write    (mem_write),
        .adr_src      (adr_src),
        .result_src   (result_src),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    // {pc_update, branch, ir_write, reg_write, mem_write, adr_src, result_src, a, b, alu_op, illegal}
    wire [14:0] outs = {pc_update, branch, ir_write, reg_write, mem_write, adr_src,
                        result_src, alu_src_a, alu_src_b, alu_op, illegal_instr};

    localparam logic [14:0] V_FETCH    = 15'b1_0_1_0_0_0_10_00_10_00_0;
    localparam logic [14:0] V_FSTALL   = 15'b0_0_0_0_0_0_10_00_10_00_0;
    localparam logic [14:0] V_RST      = 15'b0_0_0_0_0_0_10_00_10_00_0;
    localparam logic [14:0] V_DECODE   = 15'b0_0_0_0_0_0_00_01_01_00_0;
    localparam logic [14:0] V_DEC_ILL  = 15'b0_0_0_0_0_0_00_01_01_00_1;
    localparam logic [14:0] V_MEMADR   = 15'b0_0_0_0_0_0_00_10_01_00_0;
    localparam logic [14:0] V_MEMREAD  = 15'b0_0_0_0_0_1_00_00_00_00_0;
    localparam logic [14:0] V_MEMWB    = 15'b0_0_0_1_0_0_01_00_00_00_0;
    localparam logic [14:0] V_MEMWRITE = 15'b0_0_0_0_1_1_00_00_00_00_0;
    localparam logic [14:0] V_EXECR    = 15'b0_0_0_0_0_0_00_10_00_10_0;
    localparam logic [14:0] V_EXECI    = 15'b0_0_0_0_0_0_00_10_01_10_0;
    localparam logic [14:0] V_ALUWB    = 15'b0_0_0_1_0_0_00_00_00_00_0;
    localparam logic [14:0] V_BRANCH   = 15'b0_1_0_0_0_0_00_10_00_01_0;
    localparam logic [14:0] V_JAL      = 15'b1_0_0_0_0_0_00_01_10_00_0;
    localparam logic [14:0] V_JALR     = 15'b1_0_0_0_0_0_10_10_01_00_0;
    localparam logic [14:0] V_JLINK    = 15'b0_0_0_0_0_0_00_01_10_00_0;
    localparam logic [14:0] V_LUI      = 15'b0_0_0_0_0_0_00_11_01_00_0;
    localparam logic [14:0] V_AUIPC    = 15'b0_0_0_0_0_0_00_01_01_00_0;

    // Each test starts #1 after a rising edge with the FSM in FETCH and ends in FETCH
    // without advancing past it.

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b1; op = 7'b0000000;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (outs !== V_RST) begin
            bad++; $display("FAIL reset_hold got=%b exp=%b", outs, V_RST);
        end
        reset = 1'b0;
        #1;
        total++;
        if (outs !== V_FETCH) begin
            bad++; $display("FAIL reset_release got=%b exp=%b", outs, V_FETCH);
        end
    endtask

    task automatic test_load();
        logic [14:0] exp [6];
        exp = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMREAD, V_MEMWB, V_FETCH};
        op = 7'b0000011; mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            total++;
            if (outs !== exp[i]) begin
                bad++; $display("FAIL load cyc%0d got=%b exp=%b", i, outs, exp[i]);
            end
            if (i < 5) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_store_stall();
        logic [14:0] exp [8];
        logic        mr  [8];
        exp = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWRITE, V_MEMWRITE, V_MEMWRITE, V_MEMWRITE, V_FETCH};
        mr  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        op = 7'b0100011;
        for (int i = 0; i < 8; i++) begin
            mem_ready = mr[i];
            #1;
            total++;
            if (outs !== exp[i]) begin
                bad++; $display("FAIL store_stall cyc%0d got=%b exp=%b", i, outs, exp[i]);
            end
            if (i < 7) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_branch();
        logic [14:0] exp [4];
        exp = '{V_FETCH, V_DECODE, V_BRANCH, V_FETCH};
        op = 7'b1100011; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (outs !== exp[i]) begin
                bad++; $display("FAIL branch cyc%0d got=%b exp=%b", i, outs, exp[i]);
            end
            if (i < 3) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_jalr();
        logic [14:0] exp [6];
        exp = '{V_FETCH, V_DECODE, V_JALR, V_JLINK, V_ALUWB, V_FETCH};
        op = 7'b1100111; mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            total++;
            if (outs !== exp[i]) begin
                bad++; $display("FAIL jalr cyc%0d got=%b exp=%b", i, outs, exp[i]);
            end
            if (i < 5) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_illegal_then_r();
        logic [14:0] exp [7];
        logic [6:0]  ops [7];
        exp = '{V_FETCH, V_DEC_ILL, V_FETCH, V_DECODE, V_EXECR, V_ALUWB, V_FETCH};
        ops = '{7'h7F, 7'h7F, 7'h33, 7'h33, 7'h33, 7'h33, 7'h33};
        mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            op = ops[i];
            #1;
            total++;
            if (outs !== exp[i]) begin
                bad++; $display("FAIL illegal_then_r cyc%0d got=%b exp=%b", i, outs, exp[i]);
            end
            if (i < 6) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_fetch_stall_lui();
        logic [14:0] exp [7];
        logic        mr  [7];
        exp = '{V_FSTALL, V_FSTALL, V_FETCH, V_DECODE, V_LUI, V_ALUWB, V_FETCH};
        mr  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        op = 7'b0110111;
        for (int i = 0; i < 7; i++) begin
            mem_ready = mr[i];
            #1;
            total++;
            if (outs !== exp[i]) begin
                bad++; $display("FAIL fetch_stall_lui cyc%0d got=%b exp=%b", i, outs, exp[i]);
            end
            if (i < 6) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] exp [13];
        logic [6:0]  ops [13];
        exp = '{V_FETCH, V_DECODE, V_JAL, V_ALUWB,
                V_FETCH, V_DECODE, V_AUIPC, V_ALUWB,
                V_FETCH, V_DECODE, V_EXECI, V_ALUWB, V_FETCH};
        ops = '{7'h6F, 7'h6F, 7'h6F, 7'h6F,
                7'h17, 7'h17, 7'h17, 7'h17,
                7'h13, 7'h13, 7'h13, 7'h13, 7'h13};
        mem_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            op = ops[i];
            #1;
            total++;
            if (outs !== exp[i]) begin
                bad++; $display("FAIL back_to_back cyc%0d got=%b exp=%b", i, outs, exp[i]);
            end
            if (i < 12) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset_mid();
        op = 7'b0100011; mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mem_ready = 1'b0;
        #1;
        total++;
        if (outs !== V_MEMWRITE) begin
            bad++; $display("FAIL reset_mid_pre got=%b exp=%b", outs, V_MEMWRITE);
        end
        #1 reset = 1'b1;
        #1;
        total++;
        if (outs !== V_RST) begin
            bad++; $display("FAIL reset_mid_async got=%b exp=%b", outs, V_RST);
        end
        mem_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (outs !== V_RST) begin
            bad++; $display("FAIL reset_mid_hold got=%b exp=%b", outs, V_RST);
        end
        reset = 1'b0;
        #1;
        total++;
        if (outs !== V_FETCH) begin
            bad++; $display("FAIL reset_mid_release got=%b exp=%b", outs, V_FETCH);
        end
        @(posedge clk); #1;
        total++;
        if (outs !== V_DECODE) begin
            bad++; $display("FAIL reset_mid_first_fetch got=%b exp=%b", outs, V_DECODE);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; op = '0; mem_ready = 1'b0;
        test_reset();
        test_load();
        test_store_stall();
        test_branch();
        test_jalr();
        test_illegal_then_r();
        test_fetch_stall_lui();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
